// File: rtl/div24_seq.sv
// Restoring divider: 2W-bit dividend / W-bit divisor -> W-bit quotient and remainder, one bit per clock.
// Result W+1 cycles after an accepted start (1 cycle on overflow/zero divisor); start is ignored unless idle.
module div24_seq #(
   parameter int WIDTH = 24
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [2*WIDTH-1:0]   dividend,
   input  logic [WIDTH-1:0]     divisor,
   output logic                 busy,
   output logic                 done,
   output logic [WIDTH-1:0]     Q,
   output logic [WIDTH-1:0]     R,
   output logic                 ovf
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [WIDTH-1:0] div_q, div_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [WIDTH:0]   t;
   logic [WIDTH-1:0] diff;
   logic             ge;

   always_comb begin
      t     = {rem_q, sh_q[WIDTH-1]};
      ge    = (t >= {1'b0, div_q});
      // Only used when ge, where the true difference is below the divisor and fits in W bits.
      diff  = t[WIDTH-1:0] - div_q;

      state_d = state_q;
      rem_d   = rem_q;
      sh_d    = sh_q;
      div_d   = div_q;
      q_d     = q_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               div_d = divisor;
               if (dividend[2*WIDTH-1:WIDTH] >= divisor) begin
                  q_d     = '1;
                  r_d     = '0;
                  ovf_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  rem_d   = dividend[2*WIDTH-1:WIDTH];
                  sh_d    = dividend[WIDTH-1:0];
                  cnt_d   = CW'(WIDTH - 1);
                  ovf_d   = 1'b0;
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            rem_d = ge ? diff : t[WIDTH-1:0];
            // Dividend bits leave at the top while quotient bits fill in from the bottom.
            sh_d  = {sh_q[WIDTH-2:0], ge};
            if (cnt_q == '0) begin
               q_d     = sh_d;
               r_d     = rem_d;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rem_q   <= '0;
         sh_q    <= '0;
         div_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         sh_q    <= sh_d;
         div_q   <= div_d;
         q_q     <= q_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign Q    = q_q;
   assign R    = r_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_div24_seq.sv
// Randomised and directed checks of div24_seq against a plain-arithmetic division model.
module tb_div24_seq;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [47:0] dividend = '0;
   logic [23:0] divisor = '0;
   logic        busy, done, ovf;
   logic [23:0] Q, R;

   int n_cmp = 0;
   int n_fail = 0;

   div24_seq #(.WIDTH(24)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
      .busy(busy), .done(done), .Q(Q), .R(R), .ovf(ovf)
   );

   always #5 clk = ~clk;

   function automatic void ref_div(input logic [47:0] a, input logic [23:0] b,
                                   output logic [23:0] q, output logic [23:0] r, output logic o);
      logic [23:0] hi;
      hi = a[47:24];
      if (hi >= b) begin
         q = '1; r = '0; o = 1'b1;
      end else begin
         q = 24'(a / {24'b0, b});
         r = 24'(a % {24'b0, b});
         o = 1'b0;
      end
   endfunction

   // Issues one start and waits (bounded) for done; lat = edges after the accepting edge.
   task automatic run_div(input logic [47:0] a, input logic [23:0] b,
                          output logic [23:0] q, output logic [23:0] r, output logic o,
                          output int lat, output int busy_cyc, output logic done_after);
      dividend = a; divisor = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0; busy_cyc = 0;
      while (done !== 1'b1 && lat < 100) begin
         if (busy === 1'b1) busy_cyc++;
         @(posedge clk); #1;
         lat++;
      end
      if (busy === 1'b1) busy_cyc++;
      q = Q; r = R; o = ovf;
      @(posedge clk); #1;
      done_after = done;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if ({busy, done, ovf, Q, R} !== 51'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: busy=%b done=%b ovf=%b Q=%h R=%h, required all zero", busy, done, ovf, Q, R);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy, done);
      end
   endtask

   task automatic test_directed;
      logic [47:0] a_tab [3] = '{48'h600000000000, 48'hFFFFFE000001, 48'd100};
      logic [23:0] b_tab [3] = '{24'hC00000, 24'hFFFFFF, 24'd7};
      logic [23:0] q_tab [3] = '{24'h800000, 24'hFFFFFF, 24'd14};
      logic [23:0] r_tab [3] = '{24'h0, 24'h0, 24'd2};
      logic [23:0] q, r;
      logic o, da;
      int lat, bc;
      for (int i = 0; i < 3; i++) begin
         run_div(a_tab[i], b_tab[i], q, r, o, lat, bc, da);
         n_cmp++;
         if (q !== q_tab[i] || r !== r_tab[i] || o !== 1'b0) begin
            n_fail++;
            $display("FAIL directed_%0d: Q=%h R=%h ovf=%b, required Q=%h R=%h ovf=0", i, q, r, o, q_tab[i], r_tab[i]);
         end
         n_cmp++;
         if (lat != 24 || bc != 25) begin
            n_fail++;
            $display("FAIL directed_timing_%0d: latency=%0d busy_cycles=%0d, required 24 and 25", i, lat, bc);
         end
         n_cmp++;
         if (da !== 1'b0 || Q !== q_tab[i]) begin
            n_fail++;
            $display("FAIL directed_hold_%0d: done=%b Q=%h after DONE, required done=0 Q=%h", i, da, Q, q_tab[i]);
         end
      end
   endtask

   task automatic test_overflow;
      logic [47:0] a_tab [2] = '{48'h000000000123, 48'h000010000000};
      logic [23:0] b_tab [2] = '{24'h0, 24'h10};
      logic [23:0] q, r;
      logic o, da;
      int lat, bc;
      for (int i = 0; i < 2; i++) begin
         run_div(a_tab[i], b_tab[i], q, r, o, lat, bc, da);
         n_cmp++;
         if (q !== 24'hFFFFFF || r !== 24'h0 || o !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_%0d: Q=%h R=%h ovf=%b, required Q=ffffff R=000000 ovf=1", i, q, r, o);
         end
         n_cmp++;
         if (lat != 0 || da !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_timing_%0d: extra_edges=%0d done_after=%b, required 0 and 0", i, lat, da);
         end
      end
   endtask

   task automatic test_start_while_busy;
      logic [47:0] a = 48'h00123456789A;
      logic [23:0] b = 24'h0ABCDE;
      logic [23:0] eq, er, gq, gr, q, r;
      logic eo, go, o, da;
      int ndone, lat, bc;
      ref_div(a, b, eq, er, eo);
      gq = '0; gr = '0; go = 1'b0; ndone = 0;
      dividend = a; divisor = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (i == 5) begin
            start = 1'b1; dividend = 48'h000001000000; divisor = 24'h000003;
         end
         if (i == 6) start = 1'b0;
         if (i == 23) start = 1'b1;
         if (i == 25) begin
            start = 1'b0;
            n_cmp++;
            if (busy !== 1'b0) begin
               n_fail++;
               $display("FAIL busy_start_in_done: busy=%b after DONE with start held, required 0", busy);
            end
         end
         if (done === 1'b1) begin
            ndone++; gq = Q; gr = R; go = ovf;
         end
         @(posedge clk); #1;
      end
      n_cmp++;
      if (ndone != 1 || gq !== eq || gr !== er || go !== eo) begin
         n_fail++;
         $display("FAIL busy_restart: pulses=%0d Q=%h R=%h ovf=%b, required 1 Q=%h R=%h ovf=%b", ndone, gq, gr, go, eq, er, eo);
      end
      ref_div(48'h000001000000, 24'h000003, eq, er, eo);
      run_div(48'h000001000000, 24'h000003, q, r, o, lat, bc, da);
      n_cmp++;
      if (q !== eq || r !== er || o !== eo || lat != 24) begin
         n_fail++;
         $display("FAIL busy_next_idle: Q=%h R=%h ovf=%b lat=%0d, required Q=%h R=%h ovf=%b lat=24", q, r, o, lat, eq, er, eo);
      end
   endtask

   task automatic test_reset_mid_calc;
      logic [23:0] eq, er, q, r;
      logic eo, o, da;
      int ndone, lat, bc;
      dividend = 48'h000ABC123456; divisor = 24'h123457; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      n_cmp++;
      if ({busy, done, ovf, Q, R} !== 51'b0) begin
         n_fail++;
         $display("FAIL midcalc_reset: busy=%b done=%b ovf=%b Q=%h R=%h, required all zero", busy, done, ovf, Q, R);
      end
      ndone = 0;
      repeat (30) begin
         if (done === 1'b1 || busy === 1'b1) ndone++;
         @(posedge clk); #1;
      end
      n_cmp++;
      if (ndone != 0) begin
         n_fail++;
         $display("FAIL midcalc_no_done: active_cycles=%0d after reset, required 0", ndone);
      end
      ref_div(48'h000ABC123456, 24'h123457, eq, er, eo);
      run_div(48'h000ABC123456, 24'h123457, q, r, o, lat, bc, da);
      n_cmp++;
      if (q !== eq || r !== er || o !== eo) begin
         n_fail++;
         $display("FAIL midcalc_fresh: Q=%h R=%h ovf=%b, required Q=%h R=%h ovf=%b", q, r, o, eq, er, eo);
      end
   endtask

   task automatic test_random;
      logic [47:0] a;
      logic [23:0] b, hi, eq, er, q, r;
      logic eo, o, da;
      int lat, bc;
      for (int i = 0; i < 1200; i++) begin
         b = 24'($urandom);
         if (i % 5 == 0) b = 24'($urandom_range(255, 1));
         if (i % 97 == 0) b = 24'h0;
         if (($urandom & 3) != 0 && b != 24'h0) hi = 24'($urandom % {8'b0, b});
         else hi = 24'($urandom);
         a = {hi, 24'($urandom)};
         ref_div(a, b, eq, er, eo);
         run_div(a, b, q, r, o, lat, bc, da);
         n_cmp++;
         if (q !== eq || r !== er || o !== eo) begin
            n_fail++;
            $display("FAIL random_%0d a=%h b=%h: Q=%h R=%h ovf=%b, required Q=%h R=%h ovf=%b", i, a, b, q, r, o, eq, er, eo);
         end
         n_cmp++;
         if (lat != (eo ? 0 : 24)) begin
            n_fail++;
            $display("FAIL random_lat_%0d: latency=%0d, required %0d", i, lat, eo ? 0 : 24);
         end
         if (o === 1'b0) begin
            n_cmp++;
            if ({24'b0, q} * {24'b0, b} + {24'b0, r} !== a || r >= b) begin
               n_fail++;
               $display("FAIL random_identity_%0d: Q*b+R != a or R>=b (a=%h b=%h Q=%h R=%h)", i, a, b, q, r);
            end
         end
      end
   endtask

   initial begin
      test_reset;
      test_directed;
      test_overflow;
      test_start_while_busy;
      test_reset_mid_calc;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
